// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helpers for the synchronous flag FIFO.
//               Holds the default parameter values and the pointer-width
//               function (log2(depth) + 1, the extra bit being the wrap bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_AE_LEVEL   = 2;
  localparam int DEF_FWFT       = 0;

  // Storage index bits plus one wrap bit, so full and empty can be
  // told apart when the index bits match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// Module      : fifo_ram
// Description : FIFO storage array. One synchronous write port and one
//               asynchronous read port. There is no reset: contents are
//               only meaningful between the FIFO pointers.
// Ports       : clk   - write clock
//               we    - write enable
//               waddr - write index
//               wdata - write data
//               raddr - read index
//               rdata - read data (combinational from raddr)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : fifo_ram

`default_nettype wire

// File: rtl/fifo_sync_flags.sv
// ============================================================================
// Module      : fifo_sync_flags
// Description : Single-clock FIFO with occupancy count, full/empty and
//               programmable almost-full/almost-empty flags, sticky
//               overflow/underflow error flags and a synchronous flush.
//               FWFT selects registered read (0) or first-word-fall-through
//               (1) data output.
// Ports       : clk          - clock, rising edge
//               rst_n        - asynchronous active-low reset
//               cs           - chip select, gates wr_en/rd_en/flush
//               wr_en        - write request
//               rd_en        - read/pop request
//               flush        - synchronous clear of contents and error flags
//               datain       - write data
//               dataout      - read data
//               empty/full   - occupancy == 0 / == FIFO_DEPTH
//               almost_empty - count <= AE_LEVEL
//               almost_full  - count >= AF_LEVEL
//               count        - current occupancy
//               overflow     - sticky: write attempted while full
//               underflow    - sticky: read attempted while empty
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = DEF_AE_LEVEL,
  parameter int FWFT       = DEF_FWFT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cs,
  input  logic                                 wr_en,
  input  logic                                 rd_en,
  input  logic                                 flush,
  input  logic [DATA_WIDTH-1:0]                datain,
  output logic [DATA_WIDTH-1:0]                dataout,
  output logic                                 empty,
  output logic                                 full,
  output logic                                 almost_empty,
  output logic                                 almost_full,
  output logic [ptr_width(FIFO_DEPTH)-1:0]     count,
  output logic                                 overflow,
  output logic                                 underflow
);

  localparam int PW = ptr_width(FIFO_DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] C_AF_LEVEL = PW'(AF_LEVEL);
  localparam logic [PW-1:0] C_AE_LEVEL = PW'(AE_LEVEL);
  localparam logic [PW-1:0] C_PTR_ONE  = PW'(1);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  flush_hit;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // ------------------------------------------------------------------
  // Status flags: purely combinational from the registered pointers.
  // ------------------------------------------------------------------
  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[PW-1]   != rd_ptr_q[PW-1]);
  assign almost_full  = (count >= C_AF_LEVEL);
  assign almost_empty = (count <= C_AE_LEVEL);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // Flush wins over both requests; full/empty block their request even
  // when the opposite side is accepted in the same cycle.
  assign flush_hit = cs && flush;
  assign wr_acc    = cs && wr_en && !full  && !flush;
  assign rd_acc    = cs && rd_en && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush_hit) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      if (cs && wr_en && full)  ovf_d = 1'b1;
      if (cs && rd_en && empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (datain),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  // ------------------------------------------------------------------
  // Read data path
  // ------------------------------------------------------------------
  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always visible; valid whenever empty is low.
      assign dataout = ram_rdata;
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (rd_acc) dout_d = ram_rdata;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
      end

      assign dataout = dout_q;
    end
  endgenerate

endmodule : fifo_sync_flags

`default_nettype wire
